pixel_stream_scheduler: RTL and testbench

//  Drains 24-bit RGB pixels from the input-layer reg_fifo, which packs 64-bit words into
//    24-bit pixels, and presents them one per cycle on a valid/ready stream to the first conv stage.

---
 rtl/pixel_stream_scheduler.sv | 148 ++++++++++++++
 tb/tb_pixel_stream_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_scheduler.sv
// Pixel stream scheduler: drains 24-bit pixels from the input reg_fifo into a
// 2-entry skid buffer and presents them on a valid/ready stream with R/G/B
// split and column/row/eol/eof position tags. One frame per start pulse.
//
// state | meaning
// IDLE  | waiting for start, no pops
// RUN   | popping pixels until W*H have been consumed
// DRAIN | all pixels popped, waiting for the skid buffer to empty
module pixel_stream_scheduler #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  localparam int COL_W = $clog2(IMG_WIDTH),
  localparam int ROW_W = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      fifo_data,
  input  logic [3:0]       fifo_count,
  output logic             fifo_pop,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [23:0]      data;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             eol;
    logic             eof;
  } ent_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       occ_q, occ_d;
  ent_t             e0_q, e0_d, e1_q, e1_d;
  logic             done_q, done_d;

  logic pop, xfer, col_last, row_last;
  ent_t new_e;

  // Pop decision, position counters, skid buffer update and next state.
  always_comb begin
    col_last = (col_q == COL_W'(IMG_WIDTH - 1));
    row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
    // Gated by reset so nothing upstream is consumed while reset is held.
    pop  = !reset && (state_q == RUN) && (fifo_count != 4'd0) && (occ_q != 2'd2);
    xfer = (occ_q != 2'd0) && pix_ready;

    new_e.data = fifo_data;
    new_e.col  = col_q;
    new_e.row  = row_q;
    new_e.eol  = col_last;
    new_e.eof  = col_last && row_last;

    col_d   = col_q;
    row_d   = row_q;
    occ_d   = occ_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    state_d = state_q;

    if (pop) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case ({pop, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // Head entry always drives the outputs; it keeps its old value when the
    // buffer empties so the pix_* fields hold.
    if (xfer) begin
      if (occ_q == 2'd2) begin
        e0_d = e1_q;
        if (pop) e1_d = new_e;
      end else if (pop) begin
        e0_d = new_e;
      end
    end else if (pop) begin
      if (occ_q == 2'd0) e0_d = new_e;
      else               e1_d = new_e;
    end

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop && col_last && row_last) state_d = DRAIN;
      DRAIN:   if (occ_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Final transfer happens in this cycle; pulse lands in the first IDLE cycle.
    done_d = (state_q == DRAIN) && (occ_d == 2'd0);
  end

  // State, counter and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      occ_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      occ_q   <= occ_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      done_q  <= done_d;
    end
  end

  assign fifo_pop   = pop;
  assign pix_valid  = (occ_q != 2'd0);
  assign pix_r      = e0_q.data[23:16];
  assign pix_g      = e0_q.data[15:8];
  assign pix_b      = e0_q.data[7:0];
  assign pix_col    = e0_q.col;
  assign pix_row    = e0_q.row;
  assign pix_eol    = e0_q.eol;
  assign pix_eof    = e0_q.eof;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_stream_scheduler.sv
// Testbench for pixel_stream_scheduler with a 4x2 frame.
module tb_pixel_stream_scheduler;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset, start, pix_ready;
  logic [23:0] fifo_data;
  logic [3:0]  fifo_count;
  logic        fifo_pop, pix_valid, pix_eol, pix_eof, busy, frame_done;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [1:0]  pix_col;
  logic [0:0]  pix_row;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] up_q[$];

  pixel_stream_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_pop(fifo_pop),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_col(pix_col), .pix_row(pix_row), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [3:0]  cnt;
    logic [23:0] dat;
    logic        e_pop;
    logic        e_val;
    logic        e_busy;
    logic        e_fd;
    int          k;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [23:0] px(input int k);
    logic [7:0] kb;
    kb = k[7:0];
    if (k == 0) return 24'h123456;
    if (k == 1) return 24'hA5C3F0;
    return {8'h40 + kb, 8'h80 + kb, 8'hC0 + kb};
  endfunction

  function automatic vec_t mk(input logic rst, input logic st, input logic [3:0] cnt,
                              input logic [23:0] dat, input logic e_pop, input logic e_val,
                              input logic e_busy, input logic e_fd, input int k);
    vec_t v;
    v.rst = rst; v.st = st; v.cnt = cnt; v.dat = dat;
    v.e_pop = e_pop; v.e_val = e_val; v.e_busy = e_busy; v.e_fd = e_fd; v.k = k;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output fields for the k-th pixel of a frame.
  task automatic check_pix(input string tag, input int k);
    logic [23:0] d;
    d = px(k);
    chk($sformatf("%s_r%0d", tag, k), int'(pix_r), int'(d[23:16]));
    chk($sformatf("%s_g%0d", tag, k), int'(pix_g), int'(d[15:8]));
    chk($sformatf("%s_b%0d", tag, k), int'(pix_b), int'(d[7:0]));
    chk($sformatf("%s_col%0d", tag, k), int'(pix_col), k % W);
    chk($sformatf("%s_row%0d", tag, k), int'(pix_row), k / W);
    chk($sformatf("%s_eol%0d", tag, k), int'(pix_eol), int'((k % W) == W - 1));
    chk($sformatf("%s_eof%0d", tag, k), int'(pix_eof), int'(k == NPIX - 1));
  endtask

  task automatic drive_up(input bit gaps, input int cyc);
    int sz;
    sz = up_q.size();
    if (gaps) fifo_count = (((cyc / 2) % 2) == 1 && sz > 0) ? 4'd1 : 4'd0;
    else      fifo_count = (sz > 15) ? 4'd15 : 4'(sz);
    fifo_data = (sz > 0) ? up_q[0] : 24'h0;
  endtask

  // One frame against an upstream queue model and an in-order scoreboard.
  // stop_after > 0 leaves the frame after that many transfers.
  task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                           input bit gaps, input bit start_mid, input int stop_after);
    int cyc, nx, pops, stall_pops, last_x;
    bit done, held;
    logic [28:0] hold_v, cur_v;
    up_q.delete();
    for (int k = 0; k < NPIX + 2; k++) up_q.push_back(px(k));
    pix_ready = 1'b1;
    start = 1'b1;
    drive_up(gaps, 0);
    @(negedge clk);
    chk({tag, "_idle_pop"}, int'(fifo_pop), 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; nx = 0; pops = 0; stall_pops = 0; last_x = -10; done = 0; held = 0;
    hold_v = '0;
    while (!done && cyc < 200) begin
      pix_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      start = start_mid && (cyc == 3);
      drive_up(gaps, cyc);
      @(negedge clk);
      if (fifo_count == 4'd0) chk({tag, "_pop_on_empty"}, int'(fifo_pop), 0);
      if (frame_done) begin
        chk({tag, "_fd_cycle"}, cyc, last_x + 1);
        chk({tag, "_fd_busy"}, int'(busy), 0);
        done = 1;
      end
      cur_v = {pix_r, pix_g, pix_b, pix_col, pix_row, pix_eol, pix_eof};
      if (!pix_ready) begin
        if (fifo_pop) stall_pops++;
        if (pix_valid) begin
          if (held) chk({tag, "_stall_hold"}, int'(cur_v), int'(hold_v));
          hold_v = cur_v;
          held = 1;
        end
      end
      if (pix_valid && pix_ready) begin
        if (nx < NPIX) check_pix(tag, nx);
        nx++;
        last_x = cyc;
      end
      if (fifo_pop) pops++;
      @(posedge clk);
      if (fifo_pop && up_q.size() > 0) void'(up_q.pop_front());
      #1;
      cyc++;
      if (stop_after > 0 && nx >= stop_after) break;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    if (stop_after == 0) begin
      chk({tag, "_done_seen"}, int'(done), 1);
      chk({tag, "_transfers"}, nx, NPIX);
      chk({tag, "_pops"}, pops, NPIX);
      chk({tag, "_upstream_left"}, up_q.size(), 2);
      if (stall_len > 0) chk({tag, "_stall_pops_le2"}, int'(stall_pops <= 2), 1);
    end else begin
      chk({tag, "_reached_stop"}, nx, stop_after);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; fifo_count = 4'd5; fifo_data = 24'h0; pix_ready = 1'b1;
    @(posedge clk); #1;

    // Reset hold, then one 4x2 frame with continuous data and ready.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 4'd5, 24'h0, 0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 0, 4'd8, 24'h0, 0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 4'd8, px(0), 0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 0, 4'd8, px(0), 1, 0, 1, 0, -1));
    for (int j = 1; j < NPIX; j++) vecs.push_back(mk(0, 0, 4'd8, px(j), 1, 1, 1, 0, j - 1));
    vecs.push_back(mk(0, 0, 4'd8, px(NPIX), 0, 1, 1, 0, NPIX - 1));
    vecs.push_back(mk(0, 0, 4'd8, px(NPIX), 0, 0, 0, 1, -1));
    vecs.push_back(mk(0, 0, 4'd8, px(NPIX), 0, 0, 0, 0, -1));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st;
      fifo_count = vecs[i].cnt; fifo_data = vecs[i].dat; pix_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_pop", i), int'(fifo_pop), int'(vecs[i].e_pop));
      chk($sformatf("vec%0d_valid", i), int'(pix_valid), int'(vecs[i].e_val));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(frame_done), int'(vecs[i].e_fd));
      if (vecs[i].k >= 0) check_pix($sformatf("vec%0d", i), vecs[i].k);
      @(posedge clk); #1;
    end
    reset = 1'b0; start = 1'b0;

    run_frame("stall", 2, 5, 0, 0, 0);
    run_frame("gaps", 1000, 0, 1, 0, 0);
    run_frame("start_mid", 1000, 0, 0, 1, 0);

    // Reset after the fifth transfer, then a clean restart.
    run_frame("pre_reset", 1000, 0, 0, 0, 5);
    reset = 1'b1;
    drive_up(0, 0);
    @(negedge clk);
    chk("reset_cycle_pop", int'(fifo_pop), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_up(0, 0);
    @(negedge clk);
    chk("after_reset_valid", int'(pix_valid), 0);
    chk("after_reset_busy", int'(busy), 0);
    chk("after_reset_pop", int'(fifo_pop), 0);
    @(posedge clk); #1;
    run_frame("restart", 1000, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
